pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with NZCV flags and a valid/ready handshake. It is the next generation of the 16-bit four-group CLA: the width is generic, the 4-bit lookahead groups are split across a configurable number of register stages, ADD/SUB/ADC/SBC modes are supported, and a tag travels with each operation. It feeds the ALU result path, which can stall it through `out_ready`.

## Interface
- `WIDTH`, 32: operand/result width; must be a multiple of 4. GROUPS = WIDTH/4 lookahead groups.
- `STAGES`, 2: number of pipeline register stages; must satisfy 1 ≤ STAGES ≤ GROUPS and divide GROUPS. Each stage evaluates GROUPS/STAGES groups.
- `TAG_W`, 4: width of the sideband tag carried with each operation.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operation present on the inputs.
- `in_ready`  out  1: block accepts the operation this cycle.
- `a`, `b`  in  WIDTH: operands.
- `cin`  in  1: carry in, used by ADC/SBC only.
- `op`  in  2: 00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+cin), 11 SBC (a+~b+cin).
- `tag_in`  in  TAG_W: sideband data, returned unchanged.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  WIDTH: sum.
- `flag_n`, `flag_z`, `flag_c`, `flag_v`  out  1 each: negative, zero, carry, overflow.
- `tag_out`  out  TAG_W: tag of the operation on `result`.

## Operation
- Operand conditioning at the input: b_eff = b XOR {WIDTH{op[0]}}. c0 = 1 for SUB, 0 for ADD, and `cin` for ADC/SBC.
- Stage k (k = 0..STAGES-1) computes its groups with group generate/propagate signals. Within a stage, carries come from full lookahead. The stage carry-out is registered and becomes the carry-in of stage k+1. No ripple path crosses a stage register.
- Operand skew: bits for groups in stage k are delayed by k registers so they meet their carry. Sum bits from earlier stages are delayed so that all WIDTH bits reach the output register together (deskew).
- Flags, computed on the final, aligned result:
  - N = result[WIDTH-1]
  - Z = (result == 0)
  - C = carry out of bit WIDTH-1. This is the raw carry; for SUB/SBC, C=1 means no borrow.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Handshake pipeline, per stage valid bit v_k:
  - ready_k = !v_k || ready_{k+1}, with ready_STAGES = out_ready.
  - `in_ready` = ready_0, which is combinational from the stage valids and `out_ready`.
  - A stage loads when the stage behind it offers data and ready_k is high. Otherwise it holds all data, carry and tag.
  - Bubbles collapse. Capacity is STAGES operations.
- `out_valid` = v_{STAGES-1}. `result`, flags and `tag_out` are registered outputs and hold stable while out_valid && !out_ready.
- Results leave in acceptance order. No operation is dropped or duplicated.
- Elaboration fails (assertion/generate error) if WIDTH%4 ≠ 0 or GROUPS%STAGES ≠ 0.

## Timing
- Reset (rst_n low, asynchronous): all valids = 0, and `result`, flags and `tag_out` = 0. `in_ready` = 1 from the first cycle after reset, since it follows from the cleared valids.
- Reset asserted mid-operation: all in-flight operations are discarded and `out_valid` drops immediately, without waiting for a clock. Nothing is output after reset release until a new operation is accepted.
- Latency: an operation accepted at edge E appears with `out_valid` = 1 after edge E+STAGES-1, i.e. STAGES cycles of flight when unstalled. For STAGES=1 it appears after edge E itself.
- Throughput: one operation per cycle while `out_ready` = 1.
- Full pipeline with out_ready = 0: `in_ready` = 0 in the same cycle. Raising out_ready makes in_ready = 1 in that same cycle (pass-through ready), so a simultaneous input accept and output drain is allowed.
- Inputs are sampled only on the edge where in_valid && in_ready.

## Test plan
- WIDTH=32, STAGES=2, ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, N=0 Z=1 C=1 V=0, after 2 cycles.
- ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, N=1 Z=0 C=0 V=1. SUB 0x00000005 − 0x00000007 -> 0xFFFFFFFE, N=1 C=0 V=0.
- SBC 10 − 3 with cin=0 -> 6, C=1. ADC 0xFFFFFFFF + 0 with cin=1 -> 0, Z=1 C=1.
- WIDTH=16, STAGES=4, ADD 0x0FFF + 0x0001 -> 0x1000: the carry crosses every stage register. Latency is 4 cycles and tag_out equals tag_in.
- Backpressure: stream 8 random ops with tags 0..7 back to back, and hold out_ready=0 for 3 cycles mid-stream. Required: in_ready falls once STAGES ops are held, outputs stay stable while stalled, and all 8 results match the reference model in tag order.
- Reset mid-stream with 2 ops in flight: out_valid=0 without waiting for a clock edge, outputs = 0, no stale result after release, and a new op completes normally.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Purpose  : Parametrised pipelined carry-lookahead adder/subtractor with
//            ADD/SUB/ADC/SBC modes, NZCV flags, a sideband tag and a
//            valid/ready handshake whose ready chain passes through stages.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [TAG_W-1:0] tag_out
);

  localparam int GROUPS = WIDTH / 4;
  localparam int GPS    = (STAGES > 0) ? (GROUPS / STAGES) : 1;  // groups per stage
  localparam int SW     = 4 * GPS;                               // bits per stage

  // Reject illegal geometries at elaboration time.
  if (WIDTH % 4 != 0) begin : g_err_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4");
  end
  if (STAGES < 1 || STAGES > GROUPS || (GROUPS % STAGES) != 0) begin : g_err_stages
    $error("pipelined_cla_adder: STAGES must lie in 1..GROUPS and divide GROUPS");
  end

  logic [WIDTH-1:0]              b_eff;
  logic                          c0;
  logic [STAGES-1:0]             v_d, v_q, offer, load;
  logic [STAGES:0]               ready;
  logic [STAGES-1:0][WIDTH-1:0]  acc_d, acc_q;   // sum bits below the stage, raw a above
  logic [STAGES-1:0][WIDTH-1:0]  b_d, b_q;       // conditioned b travelling with its a bits
  logic [STAGES-1:0]             carry_d, carry_q;
  logic [STAGES-1:0][TAG_W-1:0]  tag_d, tag_q;
  logic                          z_d, z_q, ovf_d, ovf_q;
  logic                          unused_b_tail;

  assign b_eff = b ^ {WIDTH{op[0]}};
  assign c0    = op[1] ? cin : op[0];

  // Ready ripples back from the consumer; a stage loads when offered and ready.
  always_comb begin
    ready   = '0;
    offer   = '0;
    load    = '0;
    v_d     = '0;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = ~v_q[k] | ready[k+1];
    end
    offer[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      offer[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      load[k] = offer[k] & ready[k];
      v_d[k]  = ready[k] ? offer[k] : v_q[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [WIDTH-1:0] in_acc, in_b;
    logic             in_c;
    logic [TAG_W-1:0] in_tag;
    logic [SW-1:0]    sp, sg;
    logic [GPS-1:0]   gg, gp;
    logic [GPS:0]     gc;
    logic [SW:0]      bc;
    logic             term;

    if (k == 0) begin : g_head
      assign in_acc = a;
      assign in_b   = b_eff;
      assign in_c   = c0;
      assign in_tag = tag_in;
    end else begin : g_body
      assign in_acc = acc_q[k-1];
      assign in_b   = b_q[k-1];
      assign in_c   = carry_q[k-1];
      assign in_tag = tag_q[k-1];
    end

    // Two-level lookahead over this stage's slice: groups, then bits in a group.
    always_comb begin
      sp   = in_acc[LO +: SW] ^ in_b[LO +: SW];
      sg   = in_acc[LO +: SW] & in_b[LO +: SW];
      gg   = '0;
      gp   = '0;
      gc   = '0;
      bc   = '0;
      term = 1'b0;
      for (int j = 0; j < GPS; j++) begin
        gp[j] = &sp[4*j +: 4];
        for (int m = 0; m < 4; m++) begin
          term = sg[4*j+m];
          for (int n = m + 1; n < 4; n++) term = term & sp[4*j+n];
          gg[j] = gg[j] | term;
        end
      end
      gc[0] = in_c;
      for (int j = 0; j < GPS; j++) begin
        term = in_c;
        for (int n = 0; n <= j; n++) term = term & gp[n];
        gc[j+1] = term;
        for (int i = 0; i <= j; i++) begin
          term = gg[i];
          for (int n = i + 1; n <= j; n++) term = term & gp[n];
          gc[j+1] = gc[j+1] | term;
        end
      end
      for (int j = 0; j < GPS; j++) begin
        bc[4*j] = gc[j];
        for (int i = 1; i < 4; i++) begin
          term = gc[j];
          for (int n = 0; n < i; n++) term = term & sp[4*j+n];
          bc[4*j+i] = term;
          for (int m = 0; m < i; m++) begin
            term = sg[4*j+m];
            for (int n = m + 1; n < i; n++) term = term & sp[4*j+n];
            bc[4*j+i] = bc[4*j+i] | term;
          end
        end
      end
      bc[SW] = gc[GPS];
      acc_d[k]            = in_acc;
      acc_d[k][LO +: SW]  = sp ^ bc[SW-1:0];
      b_d[k]              = in_b;
      carry_d[k]          = bc[SW];
      tag_d[k]            = in_tag;
    end

    if (k == STAGES - 1) begin : g_tail
      // Zero and overflow are formed on the complete sum entering the output register.
      always_comb begin
        z_d   = ~|acc_d[k];
        ovf_d = bc[SW-1] ^ bc[SW];
      end
    end
  end

  // Stage registers: valids always advance, payload only moves on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= '0;
      tag_q   <= '0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          acc_q[k]   <= acc_d[k];
          b_q[k]     <= b_d[k];
          carry_q[k] <= carry_d[k];
          tag_q[k]   <= tag_d[k];
        end
      end
      if (load[STAGES-1]) begin
        z_q   <= z_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // The last stage has no consumer for its b copy; fold it away so it is pruned.
  assign unused_b_tail = ^b_q[STAGES-1];

  assign in_ready  = ready[0];
  assign out_valid = v_q[STAGES-1];
  assign result    = acc_q[STAGES-1];
  assign flag_n    = acc_q[STAGES-1][WIDTH-1];
  assign flag_z    = z_q;
  assign flag_c    = carry_q[STAGES-1];
  assign flag_v    = ovf_q;
  assign tag_out   = tag_q[STAGES-1];

endmodule
`default_nettype wire
